// File: rtl/img_lk_acc_regs.sv
// AXI4-Lite register block for the Lucas-Kanade accumulator: control,
// window parameters, captured gradient sums, IRQ and DX/DY return path.
module img_lk_acc_regs #(
    parameter int          ADDR_BITS    = 40,
    parameter int          DATA_BITS    = 64,
    parameter int          ACC_BITS     = 48,
    parameter int          OUT_BITS     = 32,
    parameter logic [63:0] CORE_ID      = 64'h527a_0000_0000_2410,
    parameter logic [63:0] CORE_VERSION = 64'h0000_0000_0001_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_BITS-1:0]   s_axi4l_awaddr,
    input  logic [2:0]             s_axi4l_awprot,
    input  logic                   s_axi4l_awvalid,
    output logic                   s_axi4l_awready,
    input  logic [DATA_BITS-1:0]   s_axi4l_wdata,
    input  logic [DATA_BITS/8-1:0] s_axi4l_wstrb,
    input  logic                   s_axi4l_wvalid,
    output logic                   s_axi4l_wready,
    output logic [1:0]             s_axi4l_bresp,
    output logic                   s_axi4l_bvalid,
    input  logic                   s_axi4l_bready,
    input  logic [ADDR_BITS-1:0]   s_axi4l_araddr,
    input  logic [2:0]             s_axi4l_arprot,
    input  logic                   s_axi4l_arvalid,
    output logic                   s_axi4l_arready,
    output logic [DATA_BITS-1:0]   s_axi4l_rdata,
    output logic [1:0]             s_axi4l_rresp,
    output logic                   s_axi4l_rvalid,
    input  logic                   s_axi4l_rready,
    input  logic [ACC_BITS-1:0]    s_acc_gxx0,
    input  logic [ACC_BITS-1:0]    s_acc_gxx1,
    input  logic [ACC_BITS-1:0]    s_acc_gyy0,
    input  logic [ACC_BITS-1:0]    s_acc_gyy1,
    input  logic                   s_acc_valid,
    output logic                   s_acc_ready,
    output logic [OUT_BITS-1:0]    m_out_dx,
    output logic [OUT_BITS-1:0]    m_out_dy,
    output logic                   m_out_valid,
    input  logic                   m_out_ready,
    output logic                   ctl_enable,
    output logic                   ctl_update,
    output logic [15:0]            param_x,
    output logic [15:0]            param_y,
    output logic [15:0]            param_width,
    output logic [15:0]            param_height,
    output logic                   irq
);

    localparam int STRB = DATA_BITS / 8;
    localparam int LSB  = $clog2(STRB);

    localparam logic [7:0] A_ID      = 8'h00, A_VER   = 8'h01, A_CTL   = 8'h04;
    localparam logic [7:0] A_IEN     = 8'h08, A_ISTAT = 8'h09, A_ICLR  = 8'h0A, A_ISET = 8'h0B;
    localparam logic [7:0] A_PX      = 8'h10, A_PY    = 8'h11, A_PW    = 8'h12, A_PH   = 8'h13;
    localparam logic [7:0] A_ACCRDY  = 8'h20, A_FULL  = 8'h21;
    localparam logic [7:0] A_GXX0    = 8'h22, A_GXX1  = 8'h23, A_GYY0  = 8'h24, A_GYY1 = 8'h25;
    localparam logic [7:0] A_DX      = 8'h30, A_DY    = 8'h31, A_OVAL  = 8'h32;

    typedef enum logic [1:0] {W_IDLE, W_HOLD, W_RESP} wst_t;

    wst_t                  wst_q, wst_d;
    logic                  aw_held_q, w_held_q;
    logic [7:0]            widx_q;
    logic [DATA_BITS-1:0]  wdata_q, wmask;
    logic [STRB-1:0]       wstrb_q;

    logic [1:0]            ctl_q;
    logic                  irq_en_q, irq_pend_q, irq_q;
    logic [15:0]           px_q, py_q, pw_q, ph_q;
    logic                  acc_full_q;
    logic [ACC_BITS-1:0]   gxx0_q, gxx1_q, gyy0_q, gyy1_q;
    logic [OUT_BITS-1:0]   dx_q, dy_q;
    logic                  oval_q;

    logic                  rvalid_q;
    logic [DATA_BITS-1:0]  rdata_q, rd_val;

    logic aw_hs, w_hs, ar_hs, acc_hs, stall, wr_go, wo_fire;

    function automatic logic [DATA_BITS-1:0] sx(input logic [ACC_BITS-1:0] v);
        return {{(DATA_BITS-ACC_BITS){v[ACC_BITS-1]}}, v};
    endfunction

    assign aw_hs   = s_axi4l_awvalid & s_axi4l_awready;
    assign w_hs    = s_axi4l_wvalid & s_axi4l_wready;
    assign ar_hs   = s_axi4l_arvalid & s_axi4l_arready;
    assign acc_hs  = s_acc_valid & s_acc_ready;
    // DX/DY must not move under a pending displacement, so hold the write back.
    assign stall   = ((widx_q == A_DX) || (widx_q == A_DY)) && oval_q;
    assign wr_go   = (wst_q == W_HOLD) && aw_held_q && w_held_q && !stall;
    assign wo_fire = wr_go && wstrb_q[0] && wdata_q[0];

    // Write-path state register.
    always_ff @(posedge clk) begin
        if (reset) wst_q <= W_IDLE;
        else       wst_q <= wst_d;
    end

    // Write-path next state and channel handshake outputs.
    always_comb begin
        wst_d           = wst_q;
        s_axi4l_awready = 1'b0;
        s_axi4l_wready  = 1'b0;
        s_axi4l_bvalid  = 1'b0;
        case (wst_q)
            W_IDLE: begin
                s_axi4l_awready = ~reset;
                s_axi4l_wready  = ~reset;
                if (aw_hs || w_hs) wst_d = W_HOLD;
            end
            W_HOLD: begin
                s_axi4l_awready = ~reset & ~aw_held_q;
                s_axi4l_wready  = ~reset & ~w_held_q;
                if (wr_go) wst_d = W_RESP;
            end
            W_RESP: begin
                s_axi4l_bvalid = 1'b1;
                if (s_axi4l_bready) wst_d = W_IDLE;
            end
            default: wst_d = W_IDLE;
        endcase
    end

    // Latch AW and W independently until the response is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (wst_q == W_RESP && s_axi4l_bready) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                widx_q    <= s_axi4l_awaddr[LSB +: 8];
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axi4l_wdata;
                wstrb_q  <= s_axi4l_wstrb;
            end
        end
    end

    // Expand byte strobes into a bit mask for RW merges.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < STRB; i++) wmask[i*8 +: 8] = {8{wstrb_q[i]}};
    end

    // RW registers, byte-merged under the strobe mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q    <= '0;
            irq_en_q <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            pw_q     <= '0;
            ph_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
        end else if (wr_go) begin
            case (widx_q)
                A_CTL: ctl_q    <= (ctl_q & ~wmask[1:0]) | (wdata_q[1:0] & wmask[1:0]);
                A_IEN: irq_en_q <= wmask[0] ? wdata_q[0] : irq_en_q;
                A_PX:  px_q     <= (px_q & ~wmask[15:0]) | (wdata_q[15:0] & wmask[15:0]);
                A_PY:  py_q     <= (py_q & ~wmask[15:0]) | (wdata_q[15:0] & wmask[15:0]);
                A_PW:  pw_q     <= (pw_q & ~wmask[15:0]) | (wdata_q[15:0] & wmask[15:0]);
                A_PH:  ph_q     <= (ph_q & ~wmask[15:0]) | (wdata_q[15:0] & wmask[15:0]);
                A_DX:  dx_q     <= (dx_q & ~wmask[OUT_BITS-1:0]) | (wdata_q[OUT_BITS-1:0] & wmask[OUT_BITS-1:0]);
                A_DY:  dy_q     <= (dy_q & ~wmask[OUT_BITS-1:0]) | (wdata_q[OUT_BITS-1:0] & wmask[OUT_BITS-1:0]);
                default: ;
            endcase
        end
    end

    // Frame capture, flags and interrupt; set events win over clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            gxx0_q     <= '0;
            gxx1_q     <= '0;
            gyy0_q     <= '0;
            gyy1_q     <= '0;
            acc_full_q <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_q      <= 1'b0;
            oval_q     <= 1'b0;
        end else begin
            if (acc_hs) begin
                gxx0_q <= s_acc_gxx0;
                gxx1_q <= s_acc_gxx1;
                gyy0_q <= s_acc_gyy0;
                gyy1_q <= s_acc_gyy1;
            end
            if (acc_hs)                              acc_full_q <= 1'b1;
            else if (wo_fire && widx_q == A_ACCRDY)  acc_full_q <= 1'b0;
            if (acc_hs || (wo_fire && widx_q == A_ISET)) irq_pend_q <= 1'b1;
            else if (wo_fire && widx_q == A_ICLR)        irq_pend_q <= 1'b0;
            if (wo_fire && widx_q == A_OVAL)  oval_q <= 1'b1;
            else if (oval_q && m_out_ready)   oval_q <= 1'b0;
            irq_q <= irq_pend_q & irq_en_q;
        end
    end

    // Read decode of the requested word.
    always_comb begin
        rd_val = '0;
        case (s_axi4l_araddr[LSB +: 8])
            A_ID:    rd_val = DATA_BITS'(CORE_ID);
            A_VER:   rd_val = DATA_BITS'(CORE_VERSION);
            A_CTL:   rd_val = DATA_BITS'(ctl_q);
            A_IEN:   rd_val = DATA_BITS'(irq_en_q);
            A_ISTAT: rd_val = DATA_BITS'(irq_pend_q & irq_en_q);
            A_PX:    rd_val = DATA_BITS'(px_q);
            A_PY:    rd_val = DATA_BITS'(py_q);
            A_PW:    rd_val = DATA_BITS'(pw_q);
            A_PH:    rd_val = DATA_BITS'(ph_q);
            A_FULL:  rd_val = DATA_BITS'(acc_full_q);
            A_GXX0:  rd_val = sx(gxx0_q);
            A_GXX1:  rd_val = sx(gxx1_q);
            A_GYY0:  rd_val = sx(gyy0_q);
            A_GYY1:  rd_val = sx(gyy1_q);
            A_DX:    rd_val = DATA_BITS'(dx_q);
            A_DY:    rd_val = DATA_BITS'(dy_q);
            A_OVAL:  rd_val = DATA_BITS'(oval_q);
            default: rd_val = '0;
        endcase
    end

    // Registered read response, held until the host takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
        end else if (rvalid_q && s_axi4l_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axi4l_arready = ~reset & ~rvalid_q;
    assign s_axi4l_rvalid  = rvalid_q;
    assign s_axi4l_rdata   = rdata_q;
    assign s_axi4l_rresp   = 2'b00;
    assign s_axi4l_bresp   = 2'b00;
    assign s_acc_ready     = ~reset & ~acc_full_q;
    assign m_out_dx        = dx_q;
    assign m_out_dy        = dy_q;
    assign m_out_valid     = oval_q;
    assign ctl_enable      = ctl_q[0];
    assign ctl_update      = ctl_q[1];
    assign param_x         = px_q;
    assign param_y         = py_q;
    assign param_width     = pw_q;
    assign param_height    = ph_q;
    assign irq             = irq_q;

    // Protection bits, undecoded address bits and unused mask/data bits.
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi4l_awprot, s_axi4l_arprot, s_axi4l_awaddr,
                         s_axi4l_araddr, wmask, wdata_q};

endmodule

// File: tb/tb_img_lk_acc_regs.sv
// Randomized bench for img_lk_acc_regs against a register-level model.
module tb_img_lk_acc_regs;

    logic        clk = 1'b0, reset;
    logic [39:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [47:0] gxx0, gxx1, gyy0, gyy1;
    logic        acc_valid, acc_ready;
    logic [31:0] dx, dy;
    logic        out_valid, out_ready;
    logic        ctl_enable, ctl_update, irq;
    logic [15:0] px, py, pw, ph;

    img_lk_acc_regs dut (
        .clk(clk), .reset(reset),
        .s_axi4l_awaddr(awaddr), .s_axi4l_awprot(awprot), .s_axi4l_awvalid(awvalid), .s_axi4l_awready(awready),
        .s_axi4l_wdata(wdata), .s_axi4l_wstrb(wstrb), .s_axi4l_wvalid(wvalid), .s_axi4l_wready(wready),
        .s_axi4l_bresp(bresp), .s_axi4l_bvalid(bvalid), .s_axi4l_bready(bready),
        .s_axi4l_araddr(araddr), .s_axi4l_arprot(arprot), .s_axi4l_arvalid(arvalid), .s_axi4l_arready(arready),
        .s_axi4l_rdata(rdata), .s_axi4l_rresp(rresp), .s_axi4l_rvalid(rvalid), .s_axi4l_rready(rready),
        .s_acc_gxx0(gxx0), .s_acc_gxx1(gxx1), .s_acc_gyy0(gyy0), .s_acc_gyy1(gyy1),
        .s_acc_valid(acc_valid), .s_acc_ready(acc_ready),
        .m_out_dx(dx), .m_out_dy(dy), .m_out_valid(out_valid), .m_out_ready(out_ready),
        .ctl_enable(ctl_enable), .ctl_update(ctl_update),
        .param_x(px), .param_y(py), .param_width(pw), .param_height(ph),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Register-level model
    logic [1:0]         m_ctl;
    logic               m_ien, m_pend, m_full, m_ov;
    logic [15:0]        m_par [4];
    logic signed [47:0] m_acc [4];
    logic [31:0]        m_dx, m_dy;

    task automatic m_reset();
        m_ctl = 0; m_ien = 0; m_pend = 0; m_full = 0; m_ov = 0; m_dx = 0; m_dy = 0;
        for (int k = 0; k < 4; k++) begin m_par[k] = 0; m_acc[k] = 0; end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mread(input int idx);
        case (idx)
            'h00: return 64'h527a_0000_0000_2410;
            'h01: return 64'h0000_0000_0001_0000;
            'h04: return 64'(m_ctl);
            'h08: return 64'(m_ien);
            'h09: return 64'(m_pend && m_ien);
            'h10, 'h11, 'h12, 'h13: return 64'(m_par[idx - 'h10]);
            'h21: return 64'(m_full);
            'h22, 'h23, 'h24, 'h25: return longint'(m_acc[idx - 'h22]);
            'h30: return 64'(m_dx);
            'h31: return 64'(m_dy);
            'h32: return 64'(m_ov);
            default: return 64'h0;
        endcase
    endfunction

    task automatic mwrite(input int idx, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] t;
        logic fire;
        fire = s[0] && d[0];
        case (idx)
            'h04: begin t = merge(64'(m_ctl), d, s); m_ctl = t[1:0]; end
            'h08: begin t = merge(64'(m_ien), d, s); m_ien = t[0]; end
            'h0A: if (fire) m_pend = 0;
            'h0B: if (fire) m_pend = 1;
            'h10, 'h11, 'h12, 'h13: begin t = merge(64'(m_par[idx-'h10]), d, s); m_par[idx-'h10] = t[15:0]; end
            'h20: if (fire) m_full = 0;
            'h30: begin t = merge(64'(m_dx), d, s); m_dx = t[31:0]; end
            'h31: begin t = merge(64'(m_dy), d, s); m_dy = t[31:0]; end
            'h32: if (fire) m_ov = 1;
            default: ;
        endcase
    endtask

    function automatic logic [39:0] mkaddr(input int idx);
        logic [7:0] i8;
        i8 = idx[7:0];
        return {29'($urandom), i8, 3'($urandom)};
    endfunction

    // AXI write with W lagging AW by wdly cycles; lat = negedges from both accepted to bvalid.
    task automatic wr(input int idx, input logic [63:0] d, input logic [7:0] s, input int wdly, output int lat);
        fork
            begin
                bit ok = 0;
                awaddr = mkaddr(idx); awvalid = 1;
                for (int n = 0; n < 100; n++) begin @(negedge clk); if (awready) begin ok = 1; break; end end
                @(posedge clk); #1 awvalid = 0;
                if (!ok) chk("aw_timeout", 0, 1);
            end
            begin
                bit ok = 0;
                for (int n = 0; n < wdly; n++) begin @(negedge clk); chk("b_before_w", bvalid, 0); @(posedge clk); end
                if (wdly > 0) #1;
                wdata = d; wstrb = s; wvalid = 1;
                for (int n = 0; n < 100; n++) begin @(negedge clk); if (wready) begin ok = 1; break; end end
                @(posedge clk); #1 wvalid = 0;
                if (!ok) chk("w_timeout", 0, 1);
            end
        join
        lat = 0; bready = 1;
        for (int n = 0; n < 100; n++) begin @(negedge clk); lat++; if (bvalid) break; end
        if (!bvalid) chk("b_timeout", 0, 1);
        else chk("bresp", bresp, 0);
        @(posedge clk); #1 bready = 0;
        mwrite(idx, d, s);
    endtask

    task automatic rd(input int idx, input int hold, output logic [63:0] d);
        bit ok = 0;
        araddr = mkaddr(idx); arvalid = 1;
        for (int n = 0; n < 100; n++) begin @(negedge clk); if (arready) begin ok = 1; break; end end
        @(posedge clk); #1 arvalid = 0;
        if (!ok) chk("ar_timeout", 0, 1);
        chk("rvalid_lat", rvalid, 1);
        d = rdata;
        for (int n = 0; n < hold; n++) begin @(posedge clk); #1 chk("rdata_hold", rdata, d); end
        rready = 1;
        @(negedge clk); @(posedge clk); #1 rready = 0;
    endtask

    task automatic rdchk(input int idx);
        logic [63:0] d;
        rd(idx, 0, d);
        chk($sformatf("rd_%0h", idx), d, mread(idx));
    endtask

    task automatic cap(input logic [47:0] a, input logic [47:0] b, input logic [47:0] c, input logic [47:0] e);
        gxx0 = a; gxx1 = b; gyy0 = c; gyy1 = e; acc_valid = 1;
        @(negedge clk); chk("acc_ready", acc_ready, !m_full);
        @(posedge clk); #1 acc_valid = 0;
        if (!m_full) begin
            m_acc[0] = a; m_acc[1] = b; m_acc[2] = c; m_acc[3] = e;
            m_full = 1; m_pend = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_outs();
        chk("irq", irq, m_pend && m_ien);
        chk("ctl", {ctl_update, ctl_enable}, m_ctl);
        chk("px", px, m_par[0]); chk("py", py, m_par[1]);
        chk("pw", pw, m_par[2]); chk("ph", ph, m_par[3]);
        chk("s_acc_ready", acc_ready, !m_full);
        chk("out_valid", out_valid, m_ov);
        chk("dx", dx, m_dx); chk("dy", dy, m_dy);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int lat, idx;
        logic [31:0] dx0, dy0;
        reset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0; acc_valid = 0; out_ready = 0;
        gxx0 = 0; gxx1 = 0; gyy0 = 0; gyy1 = 0;
        m_reset();
        idle(3);
        chk("rst_awready", awready, 0); chk("rst_arready", arready, 0); chk("rst_accready", acc_ready, 0);
        reset = 0; #1;
        chk("awready", awready, 1); chk("wready", wready, 1); chk("arready", arready, 1);
        chk("bvalid0", bvalid, 0); chk("rvalid0", rvalid, 0); chk("rdata0", rdata, 0);
        chk_outs();

        // ID registers, rdata held while rready is low
        rd('h00, 3, d); chk("core_id", d, 64'h527a_0000_0000_2410);
        rd('h01, 0, d); chk("core_ver", d, 64'h0000_0000_0001_0000);

        // PARAM_WIDTH with AW ahead of W, then a single-byte write
        wr('h12, 64'd128, 8'hFF, 3, lat);
        chk("pw_128", pw, 16'd128); rdchk('h12);
        wr('h12, 64'hFFFF, 8'h01, 0, lat);
        chk("wr_lat", lat, 2); chk("pw_strb", pw, 16'h00FF); rdchk('h12);

        // Capture with IRQ enabled; second frame blocked until ACC_READY
        wr('h08, 1, 8'hFF, 0, lat);
        cap(-48'sd5, 48'd7, 48'd100, -48'sd1);
        idle(1); chk_outs(); chk("irq_cap", irq, 1);
        rd('h22, 0, d); chk("gxx0_neg5", d, 64'hFFFF_FFFF_FFFF_FFFB);
        rdchk('h25); rdchk('h21);
        cap(48'd9, 48'd9, 48'd9, 48'd9);
        rdchk('h22);
        wr('h20, 1, 8'hFF, 0, lat);
        chk("acc_ready_back", acc_ready, 1);

        // IRQ_CLR alone, then together with a capture
        wr('h0A, 1, 8'hFF, 0, lat);
        idle(1); chk("irq_clr", irq, 0);
        fork
            wr('h0A, 1, 8'hFF, 0, lat);
            begin
                @(posedge clk); #1;
                gxx0 = 48'd11; gxx1 = 48'd22; gyy0 = 48'd33; gyy1 = 48'd44; acc_valid = 1;
                @(posedge clk); #1 acc_valid = 0;
            end
        join
        m_pend = 1; m_full = 1;
        m_acc[0] = 11; m_acc[1] = 22; m_acc[2] = 33; m_acc[3] = 44;
        idle(1); chk("irq_set_wins", irq, 1); rdchk('h09); rdchk('h23);
        wr('h20, 1, 8'hFF, 0, lat);

        // Displacement output, held while the pipeline stalls
        dx0 = 32'(8192 * 210); dy0 = 32'(-8192 * 123);
        wr('h30, 64'(dx0), 8'hFF, 0, lat);
        wr('h31, 64'(dy0), 8'hFF, 0, lat);
        wr('h32, 1, 8'hFF, 0, lat);
        chk("ov_set", out_valid, 1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("dx_stable", dx, dx0); chk("dy_stable", dy, dy0); chk("ov_hold", out_valid, 1);
        end
        @(posedge clk); #1;
        fork
            wr('h30, 64'h1234, 8'hFF, 0, lat);
            begin
                for (int n = 0; n < 10; n++) begin
                    @(negedge clk); chk("stall_no_b", bvalid, 0); chk("stall_dx", dx, dx0);
                end
                @(posedge clk); #1 out_ready = 1;
                @(posedge clk); #1 out_ready = 0;
            end
        join
        m_ov = 0;
        chk("stall_lat", lat > 10, 1);
        chk_outs(); rdchk('h30); rdchk('h32);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    case ($urandom_range(0, 7))
                        0: idx = 'h04; 1: idx = 'h08; 2: idx = 'h10; 3: idx = 'h11;
                        4: idx = 'h12; 5: idx = 'h13; 6: idx = 'h30; default: idx = 'h31;
                    endcase
                    wr(idx, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2), lat);
                end
                1: rdchk($urandom_range(0, 63));
                2: cap(48'({$urandom, $urandom}), 48'({$urandom, $urandom}),
                       48'({$urandom, $urandom}), 48'({$urandom, $urandom}));
                3: begin
                    case ($urandom_range(0, 2))
                        0: idx = 'h0A; 1: idx = 'h0B; default: idx = 'h20;
                    endcase
                    wr(idx, 64'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 0, lat);
                end
                4: wr($urandom_range('h40, 'hFF), {$urandom, $urandom}, 8'hFF, 0, lat);
                default: begin idle(1); chk_outs(); end
            endcase
        end
        idle(1); chk_outs();

        // Reset during an open read
        wr('h08, 1, 8'hFF, 0, lat);
        wr('h0B, 1, 8'hFF, 0, lat);
        idle(1); chk("irq_pre_rst", irq, 1);
        araddr = mkaddr('h00); arvalid = 1;
        @(negedge clk); @(posedge clk); #1 arvalid = 0;
        chk("open_rvalid", rvalid, 1);
        reset = 1; #1;
        chk("rst_awready2", awready, 0); chk("rst_arready2", arready, 0);
        idle(1);
        chk("rst_rvalid", rvalid, 0); chk("rst_irq", irq, 0); chk("rst_bvalid", bvalid, 0);
        reset = 0; #1;
        m_reset();
        chk_outs();
        rdchk('h12); rdchk('h08); rdchk('h22); rdchk('h30); rdchk('h04);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
        $finish;
    end

endmodule
